// File: rtl/pcm_frame_seq.sv
// pcm_frame_seq: serial PCM framer that sends a sync word followed by DATA_WORDS data words, one bit per tick.
// Data arrives through a single-entry holding buffer; a missing word is replaced by FILL_PAT and flagged.
module pcm_frame_seq #(
    parameter int                SYNC_W     = 16,
    parameter logic [SYNC_W-1:0] SYNC_PAT   = 16'hEB90,
    parameter int                WORD_W     = 8,
    parameter int                DATA_WORDS = 31,
    parameter logic [WORD_W-1:0] FILL_PAT   = 8'h55
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              en_i,
    input  logic              bit_tick_i,
    input  logic [WORD_W-1:0] data_i,
    input  logic              data_valid_i,
    output logic              data_ready_o,
    output logic              pcm_o,
    output logic              frame_start_o,
    output logic              word_start_o,
    output logic              underrun_o,
    output logic              busy_o,
    output logic [15:0]       frame_cnt_o
);
    localparam int SR_W = (SYNC_W > WORD_W) ? SYNC_W : WORD_W;
    localparam int BC_W = $clog2(SR_W + 1);
    localparam int WC_W = $clog2(DATA_WORDS + 1);
    localparam logic [BC_W-1:0] SYNC_LAST  = BC_W'(SYNC_W - 1);
    localparam logic [BC_W-1:0] WORD_LAST  = BC_W'(WORD_W - 1);
    localparam logic [WC_W-1:0] WORDS_LAST = WC_W'(DATA_WORDS - 1);
    localparam logic [SR_W-1:0] SYNC_LOAD  = SR_W'(SYNC_PAT) << (SR_W - SYNC_W);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SYNC = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [SR_W-1:0]   sr_q, sr_d;
    logic [BC_W-1:0]   bit_q, bit_d;
    logic [WC_W-1:0]   word_q, word_d;
    logic [WORD_W-1:0] buf_q, buf_d;
    logic              full_q, full_d;
    logic              fs_q, fs_d;
    logic              ws_q, ws_d;
    logic              ur_q, ur_d;
    logic [15:0]       fc_q, fc_d;
    logic              frame_last, start_sync, load_data, go_idle, shift;
    logic [SR_W-1:0]   data_sr;

    // Words are kept MSB-aligned in the shift register so pcm_o is always its top bit.
    assign data_sr    = SR_W'(full_q ? buf_q : FILL_PAT) << (SR_W - WORD_W);
    assign frame_last = state_q == ST_DATA && bit_q == WORD_LAST && word_q == WORDS_LAST;
    assign start_sync = bit_tick_i && en_i && (state_q == ST_IDLE || frame_last);
    assign go_idle    = bit_tick_i && !en_i && frame_last;
    assign load_data  = bit_tick_i && ((state_q == ST_SYNC && bit_q == SYNC_LAST) ||
                                       (state_q == ST_DATA && bit_q == WORD_LAST && !frame_last));
    assign shift      = bit_tick_i && state_q != ST_IDLE && !start_sync && !go_idle && !load_data;

    assign data_ready_o  = !full_q && state_q != ST_IDLE;
    assign busy_o        = state_q != ST_IDLE;
    assign pcm_o         = sr_q[SR_W-1];
    assign frame_start_o = fs_q;
    assign word_start_o  = ws_q;
    assign underrun_o    = ur_q;
    assign frame_cnt_o   = fc_q;

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        bit_d   = bit_q;
        word_d  = word_q;
        buf_d   = buf_q;
        full_d  = full_q;
        fs_d    = 1'b0;
        ws_d    = 1'b0;
        ur_d    = 1'b0;
        fc_d    = (bit_tick_i && frame_last) ? fc_q + 16'd1 : fc_q;
        if (start_sync) begin
            state_d = ST_SYNC;
            sr_d    = SYNC_LOAD;
            bit_d   = '0;
            word_d  = '0;
            fs_d    = 1'b1;
            ws_d    = 1'b1;
        end
        if (load_data) begin
            state_d = ST_DATA;
            sr_d    = data_sr;
            bit_d   = '0;
            word_d  = (state_q == ST_SYNC) ? '0 : word_q + 1'b1;
            ws_d    = 1'b1;
            ur_d    = !full_q;
            full_d  = 1'b0;
        end
        if (go_idle) begin
            state_d = ST_IDLE;
            sr_d    = '0;
            bit_d   = '0;
            word_d  = '0;
        end
        if (shift) begin
            sr_d  = sr_q << 1;
            bit_d = bit_q + 1'b1;
        end
        // Ready is low whenever the buffer is full, so a transfer never collides with a buffer load.
        if (data_valid_i && data_ready_o) begin
            buf_d  = data_i;
            full_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
            bit_q   <= '0;
            word_q  <= '0;
            buf_q   <= '0;
            full_q  <= 1'b0;
            fs_q    <= 1'b0;
            ws_q    <= 1'b0;
            ur_q    <= 1'b0;
            fc_q    <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            bit_q   <= bit_d;
            word_q  <= word_d;
            buf_q   <= buf_d;
            full_q  <= full_d;
            fs_q    <= fs_d;
            ws_q    <= ws_d;
            ur_q    <= ur_d;
            fc_q    <= fc_d;
        end
    end
endmodule
